// File: rtl/zpu_mem_ctrl_pkg.sv
// Shared memory-map definitions for the zpu memory controller: FSM encodings, ROM beat count,
// region type and address decode helper.
package zpu_mem_ctrl_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRomRd  = 3'd1;
  localparam logic [2:0] StRamRd  = 3'd2;
  localparam logic [2:0] StRamCap = 3'd3;
  localparam logic [2:0] StRamWr  = 3'd4;
  localparam logic [2:0] StIo     = 3'd5;
  localparam logic [2:0] StRomWr  = 3'd6;
  localparam logic [2:0] StDone   = 3'd7;

  localparam int unsigned RomBeats = 4;

  typedef enum logic [1:0] {
    RegionRom,
    RegionRam,
    RegionIo
  } region_e;

  function automatic region_e decode_region(input int unsigned addr,
                                            input int unsigned ram_base,
                                            input int unsigned io_base);
    if (addr < ram_base) return RegionRom;
    if (addr < io_base) return RegionRam;
    return RegionIo;
  endfunction

endpackage

// File: rtl/zpu_rom_word_fetch.sv
// Reads four consecutive bytes from a sync-read byte ROM and assembles them big-endian.
// Beat k drives the ROM address; its data is shifted in one cycle later.
module zpu_rom_word_fetch
  import zpu_mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  word_addr,
  input  logic [7:0]  rom_data,
  output logic [8:0]  rom_addr,
  output logic        rom_re,
  output logic        word_valid,
  output logic [31:0] word
);

  logic        busy_q;
  logic [2:0]  beat_q;
  logic [23:0] shift_q;

  assign rom_re     = busy_q && (beat_q < 3'(RomBeats));
  assign rom_addr   = rom_re ? {word_addr, beat_q[1:0]} : '0;
  assign word_valid = busy_q && (beat_q == 3'(RomBeats));
  // Last byte comes straight from the ROM so the word is ready one cycle earlier.
  assign word       = {shift_q, rom_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q  <= 1'b0;
      beat_q  <= '0;
      shift_q <= '0;
    end else if (start) begin
      busy_q <= 1'b1;
      beat_q <= '0;
    end else if (busy_q) begin
      if (beat_q != '0) shift_q <= {shift_q[15:0], rom_data};
      if (word_valid) begin
        busy_q <= 1'b0;
        beat_q <= '0;
      end else begin
        beat_q <= beat_q + 3'd1;
      end
    end
  end

endmodule

// File: rtl/zpu_mem_ctrl.sv
// Bus controller between the zpu_core memory port and on-chip ROM, RAM and the LED register.
// One access at a time; mem_done pulses for one cycle at the end of each access.
module zpu_mem_ctrl
  import zpu_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned RAM_BASE = 'h200,
  parameter int unsigned IO_BASE  = 'h300,
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned LED_W    = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data_write,
  output logic [31:0]       mem_data_read,
  output logic              mem_done,
  output logic [8:0]        rom_addr,
  output logic              rom_re,
  input  logic [7:0]        rom_data,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_re,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [LED_W-1:0]  led,
  output logic              bus_err
);

  logic [2:0]        state_q, state_d;
  logic [6:0]        rom_wa_q;
  logic [RAM_AW-1:0] ram_wa_q, ram_wa;
  logic [31:0]       wdata_q, rdata_q;
  logic [LED_W-1:0]  led_q;
  logic              wr_q, err_q;
  region_e           region;
  logic              fetch_start, fetch_valid;
  logic [31:0]       fetch_word;

  assign region      = decode_region(32'(mem_addr), RAM_BASE, IO_BASE);
  assign ram_wa      = RAM_AW'((mem_addr - ADDR_W'(RAM_BASE)) >> 2);
  assign fetch_start = (state_q == StIdle) && mem_read && !mem_write && (region == RegionRom);

  zpu_rom_word_fetch u_fetch (
    .clk        (clk),
    .reset      (reset),
    .start      (fetch_start),
    .word_addr  (rom_wa_q),
    .rom_data   (rom_data),
    .rom_addr   (rom_addr),
    .rom_re     (rom_re),
    .word_valid (fetch_valid),
    .word       (fetch_word)
  );

  // Write wins when both strobes are seen together.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mem_write) begin
          state_d = (region == RegionRom) ? StRomWr :
                    (region == RegionRam) ? StRamWr : StIo;
        end else if (mem_read) begin
          state_d = (region == RegionRom) ? StRomRd :
                    (region == RegionRam) ? StRamRd : StIo;
        end
      end
      StRomRd:  if (fetch_valid) state_d = StDone;
      StRamRd:  state_d = StRamCap;
      StRamCap: state_d = StDone;
      StRamWr:  state_d = StDone;
      StIo:     state_d = StDone;
      StRomWr:  state_d = StDone;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      rom_wa_q <= '0;
      ram_wa_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      led_q    <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle) begin
        rom_wa_q <= mem_addr[8:2];
        ram_wa_q <= ram_wa;
        wdata_q  <= mem_data_write;
        wr_q     <= mem_write;
        if (mem_write && (mem_read || region == RegionRom)) err_q <= 1'b1;
      end
      if (state_q == StRomRd && fetch_valid) rdata_q <= fetch_word;
      if (state_q == StRamCap) rdata_q <= ram_rdata;
      if (state_q == StIo) begin
        if (wr_q) led_q <= wdata_q[LED_W-1:0];
        else      rdata_q <= 32'(led_q);
      end
    end
  end

  assign mem_done      = (state_q == StDone);
  assign ram_re        = (state_q == StRamRd);
  assign ram_we        = (state_q == StRamWr);
  assign ram_addr      = (ram_re || ram_we) ? ram_wa_q : '0;
  assign ram_wdata     = ram_we ? wdata_q : '0;
  assign mem_data_read = rdata_q;
  assign led           = led_q;
  assign bus_err       = err_q;

endmodule
